// File: rtl/id_ex_reg_if.sv
// rtl/id_ex_reg_if.sv - decode-side inputs, forwarding inputs and execute-side outputs of the ID/EX register
interface id_ex_reg_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
);
    logic [1:0]       id_wd_sel;
    logic [3:0]       id_alu_op;
    logic             id_alub_sel;
    logic             id_rf_we;
    logic             id_dram_we;
    logic [2:0]       id_sext_op;
    logic [2:0]       id_branch;
    logic [1:0]       id_jump;
    logic             id_re1;
    logic             id_re2;
    logic             id_have_inst;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_pc4;
    logic [XLEN-1:0]  id_rD1;
    logic [XLEN-1:0]  id_rD2;
    logic [XLEN-1:0]  id_ext;
    logic [RADDR-1:0] id_rs1;
    logic [RADDR-1:0] id_rs2;
    logic [RADDR-1:0] id_wR;

    logic             fwd_rD1_en;
    logic [XLEN-1:0]  fwd_rD1;
    logic             fwd_rD2_en;
    logic [XLEN-1:0]  fwd_rD2;

    logic [1:0]       ex_wd_sel;
    logic [3:0]       ex_alu_op;
    logic             ex_alub_sel;
    logic             ex_rf_we;
    logic             ex_dram_we;
    logic [2:0]       ex_sext_op;
    logic [2:0]       ex_branch;
    logic [1:0]       ex_jump;
    logic             ex_re1;
    logic             ex_re2;
    logic             ex_have_inst;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_pc4;
    logic [XLEN-1:0]  ex_rD1;
    logic [XLEN-1:0]  ex_rD2;
    logic [XLEN-1:0]  ex_ext;
    logic [RADDR-1:0] ex_rs1;
    logic [RADDR-1:0] ex_rs2;
    logic [RADDR-1:0] ex_wR;
    logic             ex_valid;

    modport master (
        output id_wd_sel, id_alu_op, id_alub_sel, id_rf_we, id_dram_we, id_sext_op,
               id_branch, id_jump, id_re1, id_re2, id_have_inst, id_pc, id_pc4,
               id_rD1, id_rD2, id_ext, id_rs1, id_rs2, id_wR,
               fwd_rD1_en, fwd_rD1, fwd_rD2_en, fwd_rD2,
        input  ex_wd_sel, ex_alu_op, ex_alub_sel, ex_rf_we, ex_dram_we, ex_sext_op,
               ex_branch, ex_jump, ex_re1, ex_re2, ex_have_inst, ex_pc, ex_pc4,
               ex_rD1, ex_rD2, ex_ext, ex_rs1, ex_rs2, ex_wR, ex_valid
    );

    modport slave (
        input  id_wd_sel, id_alu_op, id_alub_sel, id_rf_we, id_dram_we, id_sext_op,
               id_branch, id_jump, id_re1, id_re2, id_have_inst, id_pc, id_pc4,
               id_rD1, id_rD2, id_ext, id_rs1, id_rs2, id_wR,
               fwd_rD1_en, fwd_rD1, fwd_rD2_en, fwd_rD2,
        output ex_wd_sel, ex_alu_op, ex_alub_sel, ex_rf_we, ex_dram_we, ex_sext_op,
               ex_branch, ex_jump, ex_re1, ex_re2, ex_have_inst, ex_pc, ex_pc4,
               ex_rD1, ex_rD2, ex_ext, ex_rs1, ex_rs2, ex_wR, ex_valid
    );
endinterface

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall hold, flush bubble and operand forwarding at capture
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    id_ex_reg_if.slave  bus
);
    typedef struct packed {
        logic             valid;
        logic [1:0]       wd_sel;
        logic [3:0]       alu_op;
        logic             alub_sel;
        logic             rf_we;
        logic             dram_we;
        logic [2:0]       sext_op;
        logic [2:0]       branch;
        logic [1:0]       jump;
        logic             re1;
        logic             re2;
        logic             have_inst;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pc4;
        logic [XLEN-1:0]  rD1;
        logic [XLEN-1:0]  rD2;
        logic [XLEN-1:0]  ext;
        logic [RADDR-1:0] rs1;
        logic [RADDR-1:0] rs2;
        logic [RADDR-1:0] wR;
    } slot_t;

    slot_t slot_q;
    slot_t slot_d;

    // Next slot contents on a load edge; forwarded operands replace register file data here
    always_comb begin
        slot_d           = '0;
        slot_d.valid     = 1'b1;
        slot_d.wd_sel    = bus.id_wd_sel;
        slot_d.alu_op    = bus.id_alu_op;
        slot_d.alub_sel  = bus.id_alub_sel;
        slot_d.rf_we     = bus.id_rf_we;
        slot_d.dram_we   = bus.id_dram_we;
        slot_d.sext_op   = bus.id_sext_op;
        slot_d.branch    = bus.id_branch;
        slot_d.jump      = bus.id_jump;
        slot_d.re1       = bus.id_re1;
        slot_d.re2       = bus.id_re2;
        slot_d.have_inst = bus.id_have_inst;
        slot_d.pc        = bus.id_pc;
        slot_d.pc4       = bus.id_pc4;
        slot_d.rD1       = bus.fwd_rD1_en ? bus.fwd_rD1 : bus.id_rD1;
        slot_d.rD2       = bus.fwd_rD2_en ? bus.fwd_rD2 : bus.id_rD2;
        slot_d.ext       = bus.id_ext;
        slot_d.rs1       = bus.id_rs1;
        slot_d.rs2       = bus.id_rs2;
        slot_d.wR        = bus.id_wR;
    end

    // Slot register: a bubble is all-zero (same as reset), flush beats stall, stall holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (flush) begin
            slot_q <= '0;
        end else if (!stall) begin
            slot_q <= slot_d;
        end
    end

    assign bus.ex_valid     = slot_q.valid;
    assign bus.ex_wd_sel    = slot_q.wd_sel;
    assign bus.ex_alu_op    = slot_q.alu_op;
    assign bus.ex_alub_sel  = slot_q.alub_sel;
    assign bus.ex_rf_we     = slot_q.rf_we;
    assign bus.ex_dram_we   = slot_q.dram_we;
    assign bus.ex_sext_op   = slot_q.sext_op;
    assign bus.ex_branch    = slot_q.branch;
    assign bus.ex_jump      = slot_q.jump;
    assign bus.ex_re1       = slot_q.re1;
    assign bus.ex_re2       = slot_q.re2;
    assign bus.ex_have_inst = slot_q.have_inst;
    assign bus.ex_pc        = slot_q.pc;
    assign bus.ex_pc4       = slot_q.pc4;
    assign bus.ex_rD1       = slot_q.rD1;
    assign bus.ex_rD2       = slot_q.rD2;
    assign bus.ex_ext       = slot_q.ext;
    assign bus.ex_rs1       = slot_q.rs1;
    assign bus.ex_rs2       = slot_q.rs2;
    assign bus.ex_wR        = slot_q.wR;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - randomized and directed checks of id_ex_reg against a reference slot model
module tb_id_ex_reg;
    localparam int XLEN  = 32;
    localparam int RADDR = 5;
    localparam int W     = 1 + 2 + 4 + 1 + 1 + 1 + 3 + 3 + 2 + 1 + 1 + 1 + 5 * XLEN + 3 * RADDR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_vec = '0;
    logic [W-1:0] act;

    id_ex_reg_if #(.XLEN(XLEN), .RADDR(RADDR)) bus ();

    id_ex_reg #(.XLEN(XLEN), .RADDR(RADDR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // What a load edge must capture, taken straight from the decode inputs and forward selects
    function automatic logic [W-1:0] load_vec();
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        r1 = bus.fwd_rD1_en ? bus.fwd_rD1 : bus.id_rD1;
        r2 = bus.fwd_rD2_en ? bus.fwd_rD2 : bus.id_rD2;
        return {1'b1, bus.id_wd_sel, bus.id_alu_op, bus.id_alub_sel, bus.id_rf_we, bus.id_dram_we,
                bus.id_sext_op, bus.id_branch, bus.id_jump, bus.id_re1, bus.id_re2, bus.id_have_inst,
                bus.id_pc, bus.id_pc4, r1, r2, bus.id_ext, bus.id_rs1, bus.id_rs2, bus.id_wR};
    endfunction

    function automatic logic [W-1:0] act_vec();
        return {bus.ex_valid, bus.ex_wd_sel, bus.ex_alu_op, bus.ex_alub_sel, bus.ex_rf_we, bus.ex_dram_we,
                bus.ex_sext_op, bus.ex_branch, bus.ex_jump, bus.ex_re1, bus.ex_re2, bus.ex_have_inst,
                bus.ex_pc, bus.ex_pc4, bus.ex_rD1, bus.ex_rD2, bus.ex_ext, bus.ex_rs1, bus.ex_rs2, bus.ex_wR};
    endfunction

    // Reference model: decide the slot's next contents from the rules, then advance one edge
    task automatic clock_edge();
        if (!rst_n || flush) exp_vec = '0;
        else if (!stall)     exp_vec = load_vec();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_wd_sel = '0; bus.id_alu_op = '0; bus.id_alub_sel = 1'b0; bus.id_rf_we = 1'b0;
        bus.id_dram_we = 1'b0; bus.id_sext_op = '0; bus.id_branch = '0; bus.id_jump = '0;
        bus.id_re1 = 1'b0; bus.id_re2 = 1'b0; bus.id_have_inst = 1'b0; bus.id_pc = '0;
        bus.id_pc4 = '0; bus.id_rD1 = '0; bus.id_rD2 = '0; bus.id_ext = '0; bus.id_rs1 = '0;
        bus.id_rs2 = '0; bus.id_wR = '0; bus.fwd_rD1_en = 1'b0; bus.fwd_rD1 = '0;
        bus.fwd_rD2_en = 1'b0; bus.fwd_rD2 = '0;
    endtask

    task automatic random_inputs();
        bus.id_wd_sel = 2'($urandom); bus.id_alu_op = 4'($urandom); bus.id_alub_sel = 1'($urandom);
        bus.id_rf_we = 1'($urandom); bus.id_dram_we = 1'($urandom); bus.id_sext_op = 3'($urandom);
        bus.id_branch = 3'($urandom); bus.id_jump = 2'($urandom); bus.id_re1 = 1'($urandom);
        bus.id_re2 = 1'($urandom); bus.id_have_inst = 1'($urandom); bus.id_pc = $urandom;
        bus.id_pc4 = bus.id_pc + 32'd4; bus.id_rD1 = $urandom; bus.id_rD2 = $urandom;
        bus.id_ext = $urandom; bus.id_rs1 = 5'($urandom); bus.id_rs2 = 5'($urandom);
        bus.id_wR = 5'($urandom); bus.fwd_rD1_en = 1'($urandom); bus.fwd_rD1 = $urandom;
        bus.fwd_rD2_en = 1'($urandom); bus.fwd_rD2 = $urandom;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.id_wd_sel = '1; bus.id_alu_op = '1; bus.id_alub_sel = 1'b1; bus.id_rf_we = 1'b1;
        bus.id_dram_we = 1'b1; bus.id_sext_op = '1; bus.id_branch = '1; bus.id_jump = '1;
        bus.id_re1 = 1'b1; bus.id_re2 = 1'b1; bus.id_have_inst = 1'b1; bus.id_pc = '1;
        bus.id_pc4 = '1; bus.id_rD1 = '1; bus.id_rD2 = '1; bus.id_ext = '1; bus.id_rs1 = '1;
        bus.id_rs2 = '1; bus.id_wR = '1;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clock_edge();
            act = act_vec();
            tests++;
            if (act !== '0) begin
                fails++;
                $display("FAIL reset_hold edge %0d got %h want 0", i, act);
            end
        end
        rst_n = 1'b1;
        #1;
        act = act_vec();
        tests++;
        if (act !== '0) begin
            fails++;
            $display("FAIL reset_release got %h want 0", act);
        end
        clock_edge();
        act = act_vec();
        tests++;
        if (act !== {W{1'b1}} || act !== exp_vec) begin
            fails++;
            $display("FAIL reset_first_load got %h want %h", act, {W{1'b1}});
        end
    endtask

    task automatic test_load_add();
        clear_inputs();
        stall = 1'b0; flush = 1'b0;
        bus.id_pc = 32'h10; bus.id_pc4 = 32'h14; bus.id_alu_op = 4'd0; bus.id_rf_we = 1'b1;
        bus.id_wR = 5'd3; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_rD1 = 32'd5; bus.id_rD2 = 32'd7;
        bus.id_re1 = 1'b1; bus.id_re2 = 1'b1; bus.id_have_inst = 1'b1;
        clock_edge();
        tests++;
        if (bus.ex_pc !== 32'h10 || bus.ex_pc4 !== 32'h14 || bus.ex_rD1 !== 32'd5 ||
            bus.ex_rD2 !== 32'd7 || bus.ex_wR !== 5'd3 || bus.ex_valid !== 1'b1 || bus.ex_rf_we !== 1'b1) begin
            fails++;
            $display("FAIL load_add got pc=%h pc4=%h rD1=%h rD2=%h wR=%0d valid=%b rf_we=%b want 10 14 5 7 3 1 1",
                     bus.ex_pc, bus.ex_pc4, bus.ex_rD1, bus.ex_rD2, bus.ex_wR, bus.ex_valid, bus.ex_rf_we);
        end
        act = act_vec();
        tests++;
        if (act !== exp_vec) begin
            fails++;
            $display("FAIL load_add_all got %h want %h", act, exp_vec);
        end
    endtask

    task automatic test_stall();
        clear_inputs();
        stall = 1'b0; flush = 1'b0;
        bus.id_pc = 32'h20; bus.id_pc4 = 32'h24; bus.id_dram_we = 1'b1; bus.id_have_inst = 1'b1;
        clock_edge();
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.id_pc = 32'h20 + 32'(4 * i);
            bus.id_pc4 = bus.id_pc + 32'd4;
            bus.id_dram_we = 1'b0;
            bus.fwd_rD1_en = 1'b1; bus.fwd_rD1 = $urandom;
            clock_edge();
            tests++;
            if (bus.ex_pc !== 32'h20 || bus.ex_dram_we !== 1'b1 || bus.ex_valid !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold cycle %0d got pc=%h dram_we=%b valid=%b want 20 1 1",
                         i, bus.ex_pc, bus.ex_dram_we, bus.ex_valid);
            end
        end
        stall = 1'b0;
        clock_edge();
        tests++;
        if (bus.ex_pc !== 32'h2C || act_vec() !== exp_vec) begin
            fails++;
            $display("FAIL stall_release got pc=%h want 2c", bus.ex_pc);
        end
    endtask

    task automatic test_flush_over_stall();
        clear_inputs();
        stall = 1'b0; flush = 1'b0;
        bus.id_branch = 3'b001; bus.id_have_inst = 1'b1; bus.id_re1 = 1'b1; bus.id_re2 = 1'b1;
        bus.id_pc = 32'h40; bus.id_pc4 = 32'h44; bus.id_rf_we = 1'b1;
        clock_edge();
        tests++;
        if (bus.ex_branch !== 3'b001 || bus.ex_valid !== 1'b1) begin
            fails++;
            $display("FAIL beq_load got branch=%b valid=%b want 001 1", bus.ex_branch, bus.ex_valid);
        end
        stall = 1'b1; flush = 1'b1;
        clock_edge();
        tests++;
        if (bus.ex_branch !== 3'b000 || bus.ex_rf_we !== 1'b0 || bus.ex_dram_we !== 1'b0 ||
            bus.ex_have_inst !== 1'b0 || bus.ex_valid !== 1'b0 || act_vec() !== '0) begin
            fails++;
            $display("FAIL flush_over_stall got %h want 0", act_vec());
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_forward();
        clear_inputs();
        stall = 1'b0; flush = 1'b0;
        bus.id_rD1 = 32'h1111_1111; bus.fwd_rD1_en = 1'b1; bus.fwd_rD1 = 32'hDEAD_BEEF;
        bus.fwd_rD2_en = 1'b0; bus.fwd_rD2 = 32'h9999_9999; bus.id_rD2 = 32'h22; bus.id_have_inst = 1'b1;
        clock_edge();
        tests++;
        if (bus.ex_rD1 !== 32'hDEAD_BEEF || bus.ex_rD2 !== 32'h22) begin
            fails++;
            $display("FAIL forward_load got rD1=%h rD2=%h want deadbeef 22", bus.ex_rD1, bus.ex_rD2);
        end
        stall = 1'b1;
        bus.fwd_rD1 = 32'h0BAD_F00D; bus.fwd_rD2_en = 1'b1; bus.fwd_rD2 = 32'h1234_5678;
        clock_edge();
        tests++;
        if (bus.ex_rD1 !== 32'hDEAD_BEEF || bus.ex_rD2 !== 32'h22) begin
            fails++;
            $display("FAIL forward_stall got rD1=%h rD2=%h want deadbeef 22", bus.ex_rD1, bus.ex_rD2);
        end
        stall = 1'b0;
    endtask

    task automatic test_async_reset();
        clear_inputs();
        stall = 1'b0; flush = 1'b0;
        bus.id_jump = 2'b11; bus.id_have_inst = 1'b1; bus.id_rf_we = 1'b1; bus.id_wR = 5'd1;
        clock_edge();
        tests++;
        if (bus.ex_jump !== 2'b11 || bus.ex_valid !== 1'b1) begin
            fails++;
            $display("FAIL jal_load got jump=%b valid=%b want 11 1", bus.ex_jump, bus.ex_valid);
        end
        #2;
        rst_n = 1'b0;
        exp_vec = '0;
        #1;
        tests++;
        if (bus.ex_jump !== 2'b00 || bus.ex_valid !== 1'b0 || act_vec() !== '0) begin
            fails++;
            $display("FAIL async_reset got %h want 0", act_vec());
        end
        #1;
        rst_n = 1'b1;
        stall = 1'b1;
        clock_edge();
        tests++;
        if (act_vec() !== '0) begin
            fails++;
            $display("FAIL reset_then_stall got %h want 0", act_vec());
        end
        stall = 1'b0;
        clock_edge();
        tests++;
        if (bus.ex_jump !== 2'b11 || bus.ex_valid !== 1'b1 || act_vec() !== exp_vec) begin
            fails++;
            $display("FAIL reset_then_load got %h want %h", act_vec(), exp_vec);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            random_inputs();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            clock_edge();
            act = act_vec();
            tests++;
            if (act !== exp_vec) begin
                fails++;
                $display("FAIL random cycle %0d stall=%b flush=%b got %h want %h",
                         i, stall, flush, act, exp_vec);
            end
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_add();
        test_stall();
        test_flush_over_stall();
        test_forward();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
